// File: rtl/obi_mem_responder.sv
// obi_mem_responder: word-organised RAM behind a req/gnt/rvalid bus.
// Requests are granted while fewer than MAX_OUTSTANDING responses are pending.
// Responses come back in order, LATENCY cycles after the accepting edge.
module obi_mem_responder #(
   parameter int unsigned DEPTH           = 4096,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int unsigned LATENCY         = 1,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        stall_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW      = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [31:0] SPAN    = 32'(DEPTH) << 2;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

   logic [31:0]        mem [DEPTH];

   logic [31:0]        offset;
   logic [AW-1:0]      idx;
   logic               dec_err;
   logic               accept;
   logic               retire;

   logic [CW-1:0]      cnt_q, cnt_d;
   logic [LATENCY-1:0] vld_q, vld_d;
   logic [LATENCY-1:0] err_q, err_d;
   logic [31:0]        data_q [LATENCY];
   logic [31:0]        data_d [LATENCY];

   // Address decode and handshake. A slot freed by the response leaving this
   // cycle can be reused in the same cycle, so a full counter still grants
   // while rvalid_o is high; this keeps MAX_OUTSTANDING = LATENCY at one
   // transaction per cycle. Only registered state feeds the grant.
   always_comb begin
      offset  = addr_i - BASE_ADDR;
      idx     = offset[AW+1:2];
      dec_err = (offset >= SPAN) || (addr_i[1:0] != 2'b00);
      retire  = vld_q[LATENCY-1];
      gnt_o   = req_i & ~stall_i & ((cnt_q < MAX_CNT) | retire);
      accept  = req_i & gnt_o;
   end

   // Outstanding counter: up on accept, down when a response leaves.
   always_comb begin
      cnt_d = cnt_q;
      if (accept && !retire) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!accept && retire) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Response pipeline next state: stage 0 takes the new response (or a
   // bubble), every later stage takes its predecessor.
   always_comb begin
      vld_d[0]  = accept;
      err_d[0]  = dec_err;
      data_d[0] = (we_i || dec_err) ? 32'h0 : mem[idx];
      for (int i = 1; i < LATENCY; i++) begin
         vld_d[i]  = vld_q[i-1];
         err_d[i]  = err_q[i-1];
         data_d[i] = data_q[i-1];
      end
   end

   // Control state: reset drops every in-flight response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         vld_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         vld_q <= vld_d;
      end
   end

   // Response payload; only meaningful where the matching valid bit is set.
   always_ff @(posedge clk) begin
      err_q  <= err_d;
      data_q <= data_d;
   end

   // Byte-enabled write into the array; errored accesses leave it untouched.
   always_ff @(posedge clk) begin
      if (accept && we_i && !dec_err) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Outputs are zero unless a response is presented.
   always_comb begin
      rvalid_o = vld_q[LATENCY-1];
      err_o    = vld_q[LATENCY-1] & err_q[LATENCY-1];
      rdata_o  = vld_q[LATENCY-1] ? data_q[LATENCY-1] : 32'h0;
   end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: three instances with different latency and
// outstanding limits, a vector table on the LATENCY = 1 instance, and
// hand-written sequences for bursts, stalls and reset mid-flight.
module tb_obi_mem_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req    [3];
   logic        we     [3];
   logic        stall  [3];
   logic        gnt    [3];
   logic        rvalid [3];
   logic        err    [3];
   logic [3:0]  be     [3];
   logic [31:0] addr   [3];
   logic [31:0] wdata  [3];
   logic [31:0] rdata  [3];

   int n_checks = 0;
   int n_fail   = 0;

   obi_mem_responder #(.DEPTH(64), .BASE_ADDR(32'h1000_0000), .LATENCY(1), .MAX_OUTSTANDING(2)) u_a (
      .clk(clk), .rst(rst), .req_i(req[0]), .gnt_o(gnt[0]), .we_i(we[0]), .be_i(be[0]),
      .addr_i(addr[0]), .wdata_i(wdata[0]), .stall_i(stall[0]), .rvalid_o(rvalid[0]),
      .rdata_o(rdata[0]), .err_o(err[0]));

   obi_mem_responder #(.DEPTH(16), .BASE_ADDR(32'h0000_0000), .LATENCY(4), .MAX_OUTSTANDING(2)) u_b (
      .clk(clk), .rst(rst), .req_i(req[1]), .gnt_o(gnt[1]), .we_i(we[1]), .be_i(be[1]),
      .addr_i(addr[1]), .wdata_i(wdata[1]), .stall_i(stall[1]), .rvalid_o(rvalid[1]),
      .rdata_o(rdata[1]), .err_o(err[1]));

   obi_mem_responder #(.DEPTH(16), .BASE_ADDR(32'h0000_0000), .LATENCY(3), .MAX_OUTSTANDING(3)) u_c (
      .clk(clk), .rst(rst), .req_i(req[2]), .gnt_o(gnt[2]), .we_i(we[2]), .be_i(be[2]),
      .addr_i(addr[2]), .wdata_i(wdata[2]), .stall_i(stall[2]), .rvalid_o(rvalid[2]),
      .rdata_o(rdata[2]), .err_o(err[2]));

   typedef struct {
      logic        w;
      logic [3:0]  b;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_d;
      logic        exp_e;
   } vec_t;

   vec_t tv [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One isolated transaction on an idle instance: immediate grant, response
   // exactly lat edges after the accept, then no further response.
   task automatic single(input int k, input int lat, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic exp_e, input string name);
      int n;
      @(negedge clk);
      req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
      #1;
      check({name, " gnt"}, {31'b0, gnt[k]}, 32'd1);
      n = 0;
      while (!gnt[k] && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (!gnt[k]) begin
         req[k] = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req[k] = 1'b0;
      n = 1;
      while (!rvalid[k] && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check({name, " latency"}, 32'(n), 32'(lat));
      check({name, " rvalid"}, {31'b0, rvalid[k]}, 32'd1);
      check({name, " rdata"}, rdata[k], exp_d);
      check({name, " err"}, {31'b0, err[k]}, {31'b0, exp_e});
      @(posedge clk); #1;
      check({name, " single rsp"}, {31'b0, rvalid[k]}, 32'd0);
   endtask

   // Eight back-to-back reads of words 0..7 under continuous request, with an
   // optional stall window [s0, s1]; checks grant pattern, order, latency,
   // outstanding bound and response count.
   task automatic burst(input int k, input int lat, input int maxo, input logic [9:0] gpat,
                        input int s0, input int s1, input logic [31:0] val0, input string name);
      int   acc_cyc [8];
      int   issued, got, outs;
      logic g;
      issued = 0; got = 0; outs = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         stall[k] = (cyc >= s0 && cyc <= s1);
         req[k]   = (issued < 8);
         we[k]    = 1'b0;
         be[k]    = 4'hF;
         addr[k]  = 32'(issued * 4);
         #1;
         g = gnt[k];
         if (cyc < 10) check({name, " gnt pattern"}, {31'b0, g}, {31'b0, gpat[cyc]});
         if (rvalid[k]) begin
            if (got < 8) begin
               check({name, " rdata order"}, rdata[k], val0 + 32'(got));
               check({name, " latency"}, 32'(cyc - acc_cyc[got]), 32'(lat));
               check({name, " err"}, {31'b0, err[k]}, 32'd0);
               got++;
               outs--;
            end else begin
               check({name, " extra rsp"}, 32'd1, 32'd0);
            end
         end
         if (req[k] && g) begin
            acc_cyc[issued] = cyc;
            issued++;
            outs++;
         end
         check({name, " outstanding bound"}, {31'b0, (outs <= maxo)}, 32'd1);
      end
      check({name, " rsp count"}, 32'(got), 32'd8);
      req[k]   = 1'b0;
      stall[k] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0]  = '{1'b1, 4'hF, 32'h1000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      tv[1]  = '{1'b0, 4'hF, 32'h1000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      tv[2]  = '{1'b1, 4'hF, 32'h1000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0};
      tv[3]  = '{1'b1, 4'h5, 32'h1000_0020, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
      tv[4]  = '{1'b0, 4'hF, 32'h1000_0020, 32'h0000_0000, 32'h11BB_33DD, 1'b0};
      tv[5]  = '{1'b1, 4'hF, 32'h1000_0000, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
      tv[6]  = '{1'b0, 4'hF, 32'h1000_0100, 32'h0000_0000, 32'h0000_0000, 1'b1};
      tv[7]  = '{1'b1, 4'hF, 32'h1000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      tv[8]  = '{1'b0, 4'hF, 32'h1000_0000, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
      tv[9]  = '{1'b0, 4'hF, 32'h0FFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1};
      tv[10] = '{1'b1, 4'h0, 32'h1000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tv[11] = '{1'b0, 4'h0, 32'h1000_0020, 32'h0000_0000, 32'h11BB_33DD, 1'b0};
      tv[12] = '{1'b1, 4'hF, 32'h1000_00FC, 32'h1234_5678, 32'h0000_0000, 1'b0};
      tv[13] = '{1'b0, 4'hF, 32'h1000_00FC, 32'h0000_0000, 32'h1234_5678, 1'b0};
      tv[14] = '{1'b0, 4'hF, 32'h1000_00FE, 32'h0000_0000, 32'h0000_0000, 1'b1};

      for (int k = 0; k < 3; k++) begin
         req[k] = 1'b0; we[k] = 1'b0; stall[k] = 1'b0;
         be[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
      end
      rst = 1'b1;

      // Reset state and the combinational grant equation while in reset.
      @(negedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         check("reset rvalid", {31'b0, rvalid[k]}, 32'd0);
         check("reset rdata", rdata[k], 32'd0);
         check("reset err", {31'b0, err[k]}, 32'd0);
      end
      req[0] = 1'b1; #1;
      check("reset gnt", {31'b0, gnt[0]}, 32'd1);
      stall[0] = 1'b1; #1;
      check("stall gnt", {31'b0, gnt[0]}, 32'd0);
      req[0] = 1'b0; stall[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Vector table on the LATENCY = 1 instance.
      for (int i = 0; i < 15; i++) begin
         single(0, 1, tv[i].w, tv[i].b, tv[i].a, tv[i].d, tv[i].exp_d, tv[i].exp_e,
                $sformatf("vec%0d", i));
      end

      // Read accepted in the cycle right after a write to the same word.
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h1000_0030; wdata[0] = 32'h55AA_55AA;
      #1;
      check("raw wr gnt", {31'b0, gnt[0]}, 32'd1);
      @(posedge clk); #1;
      we[0] = 1'b0;
      check("raw rd gnt", {31'b0, gnt[0]}, 32'd1);
      check("raw wr rvalid", {31'b0, rvalid[0]}, 32'd1);
      check("raw wr rdata", rdata[0], 32'h0);
      @(posedge clk); #1;
      req[0] = 1'b0;
      check("raw rd rvalid", {31'b0, rvalid[0]}, 32'd1);
      check("raw rd rdata", rdata[0], 32'h55AA_55AA);
      @(posedge clk); #1;
      check("raw idle", {31'b0, rvalid[0]}, 32'd0);

      // Fill words 0..7 of the other two instances.
      for (int i = 0; i < 8; i++) begin
         single(1, 4, 1'b1, 4'hF, 32'(i * 4), 32'hB000_0000 + 32'(i), 32'h0, 1'b0, "b fill");
         single(2, 3, 1'b1, 4'hF, 32'(i * 4), 32'hC000_0000 + 32'(i), 32'h0, 1'b0, "c fill");
      end

      // LATENCY 4 / MAX 2: grants 1,1,0,0,1,1,0,0,1,1.
      burst(1, 4, 2, 10'b1100110011, -1, -1, 32'hB000_0000, "b burst");
      // LATENCY 3 / MAX 3 with a two-cycle stall: 1,1,1,0,0,1,1,1,1,1.
      burst(2, 3, 3, 10'b1111100111, 3, 4, 32'hC000_0000, "c burst");

      // Reset while two reads are in flight on the LATENCY 4 instance.
      @(negedge clk);
      req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h0;
      @(posedge clk); #1;
      addr[1] = 32'h4;
      @(posedge clk); #1;
      req[1] = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      check("pre-reset rvalid", {31'b0, rvalid[1]}, 32'd1);
      check("pre-reset rdata", rdata[1], 32'hB000_0000);
      rst = 1'b1; #1;
      check("async reset rvalid", {31'b0, rvalid[1]}, 32'd0);
      check("async reset rdata", rdata[1], 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         check("post-reset quiet", {31'b0, rvalid[1]}, 32'd0);
      end
      single(1, 4, 1'b0, 4'hF, 32'h1C, 32'h0, 32'hB000_0007, 1'b0, "b read after reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
